// File: rtl/iter_datapath_pkg.sv
// Shared constants, counter-width helper and sequencer strobe bundle for
// the halving-sum datapath.
package iter_datapath_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_ACC_WIDTH = 16;
  localparam int DEF_ITERS     = 4;

  function automatic int cnt_width(input int iters);
    int w;
    w = $clog2(iters);
    return (w < 1) ? 1 : w;
  endfunction

  typedef struct packed {
    logic sel;
    logic en0;
    logic en1;
    logic en2;
    logic en3;
    logic done;
  } strobe_t;

endpackage

// File: rtl/iter_datapath_if.sv
// Sequencer <-> datapath link: control strobes one way, loop-complete back.
interface iter_datapath_if;
  import iter_datapath_pkg::*;

  strobe_t stb;
  logic    complete;

  modport master (output stb, input complete);
  modport slave  (input stb, output complete);
endinterface

// File: rtl/iter_datapath_load_reg.sv
// Enable-gated register with synchronous active-low reset.
module load_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst)    q <= '0;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/iter_datapath.sv
// Halving-sum datapath: RES = X + X>>1 + ... over ITERS terms, driven by the
// external start/done sequencer's strobes.
module iter_datapath
  import iter_datapath_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int ITERS     = DEF_ITERS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     din,
  iter_datapath_if.slave       sif,
  output logic [ACC_WIDTH-1:0] res,
  output logic                 res_valid,
  output logic                 ovf
);

  localparam int CNT_W = cnt_width(ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  logic [WIDTH-1:0]     x_q, y_q, y_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH:0]   sum;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 y_ld, acc_ld, cnt_ld, res_ld;

  // en0 starts a job and masks every other strobe in the same cycle.
  always_comb begin
    y_ld   = sif.stb.en1 & ~sif.stb.en0;
    y_d    = sif.stb.sel ? x_q : (y_q >> 1);
    sum    = {1'b0, acc_q} + (ACC_WIDTH + 1)'(y_q);
    acc_ld = ~sif.stb.en0 & (sif.stb.en2 | sif.stb.en3);
    acc_d  = sif.stb.en2 ? '0 : sum[ACC_WIDTH-1:0];
    cnt_ld = sif.stb.en0 | sif.stb.en3;
    if (sif.stb.en0)            cnt_d = '0;
    else if (cnt_q == CNT_LAST) cnt_d = cnt_q;
    else                        cnt_d = cnt_q + CNT_W'(1);
    res_ld = sif.stb.done & ~sif.stb.en0;
  end

  assign sif.complete = (cnt_q == CNT_LAST);

  load_reg #(.W(WIDTH))     u_x   (.clk(clk), .rst(rst), .ld(sif.stb.en0), .d(din),   .q(x_q));
  load_reg #(.W(WIDTH))     u_y   (.clk(clk), .rst(rst), .ld(y_ld),        .d(y_d),   .q(y_q));
  load_reg #(.W(ACC_WIDTH)) u_acc (.clk(clk), .rst(rst), .ld(acc_ld),      .d(acc_d), .q(acc_q));
  load_reg #(.W(ACC_WIDTH)) u_res (.clk(clk), .rst(rst), .ld(res_ld),      .d(acc_q), .q(res));
  load_reg #(.W(CNT_W))     u_cnt (.clk(clk), .rst(rst), .ld(cnt_ld),      .d(cnt_d), .q(cnt_q));

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf       <= 1'b0;
      res_valid <= 1'b0;
    end else if (sif.stb.en0) begin
      res_valid <= 1'b0;
    end else begin
      if (sif.stb.en2)      ovf <= 1'b0;
      else if (sif.stb.en3) ovf <= ovf | sum[ACC_WIDTH];
      if (sif.stb.done)     res_valid <= 1'b1;
    end
  end

endmodule
